// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared control-bit indices, noise LFSR constants and noise output mapping
package sid_pkg;

    localparam int CTRL_GATE  = 0;
    localparam int CTRL_SYNC  = 1;
    localparam int CTRL_RING  = 2;
    localparam int CTRL_TEST  = 3;
    localparam int CTRL_TRI   = 4;
    localparam int CTRL_SAW   = 5;
    localparam int CTRL_PULSE = 6;
    localparam int CTRL_NOISE = 7;

    localparam int          LFSR_W    = 23;
    localparam logic [22:0] LFSR_SEED = 23'h7FFFF8;
    localparam int          TAP_A     = 22;
    localparam int          TAP_B     = 17;

    // LFSR bits routed to noise[11:4], most significant first
    localparam int NOISE_BITS [8] = '{22, 20, 16, 13, 11, 7, 4, 2};

    typedef logic [11:0] sample_t;

    function automatic sample_t noise_map(input logic [22:0] s);
        sample_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[11-i] = s[NOISE_BITS[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// rtl/noise_lfsr.sv - 23-bit noise LFSR advanced on each rising edge of accumulator bit 19
module noise_lfsr
    import sid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        test,
    input  logic        bit19,
    output logic [22:0] state
);

    logic bit19_prev;

    // Seed on reset or test; otherwise shift once per 0->1 transition of bit19.
    // The previous-bit register keeps tracking during test so a level held high
    // across test release is not mistaken for an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LFSR_SEED;
            bit19_prev <= 1'b0;
        end else begin
            bit19_prev <= bit19;
            if (test) begin
                state <= LFSR_SEED;
            end else if (bit19 && !bit19_prev) begin
                state <= {state[21:0], state[TAP_A] ^ state[TAP_B]};
            end
        end
    end

endmodule

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - oscillator waveform selector/combiner; optional ring modulation via WAVE_GEN_RING_MOD_EN
module wave_gen
    import sid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] accIn,
    input  logic [7:0]  ctrl,
    input  logic [11:0] pw,
    input  logic        ringMsb,
    output logic [11:0] waveOut
);

    logic [22:0] lfsr_state;
    logic        tri_msb;
    sample_t     saw_w;
    sample_t     tri_w;
    sample_t     pulse_w;
    sample_t     noise_w;
    sample_t     wave_next;
    logic        any_sel;

`ifdef WAVE_GEN_RING_MOD_EN
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[CTRL_SYNC:CTRL_GATE];
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[CTRL_RING:CTRL_GATE], ringMsb};
`endif

    noise_lfsr u_noise (
        .clk   (clk),
        .rst   (rst),
        .test  (ctrl[CTRL_TEST]),
        .bit19 (accIn[19]),
        .state (lfsr_state)
    );

    // Build each waveform from the current phase and AND together the selected ones.
    // Noise uses the LFSR value before any shift happening on this same edge.
    always_comb begin
        tri_msb = accIn[23];
`ifdef WAVE_GEN_RING_MOD_EN
        if (ctrl[CTRL_RING]) begin
            tri_msb = accIn[23] ^ ringMsb;
        end
`endif
        saw_w   = accIn[23:12];
        tri_w   = tri_msb ? ~accIn[22:11] : accIn[22:11];
        pulse_w = ((accIn[23:12] >= pw) || ctrl[CTRL_TEST]) ? 12'hFFF : 12'h000;
        noise_w = noise_map(lfsr_state);

        wave_next = 12'hFFF;
        any_sel   = 1'b0;
        if (ctrl[CTRL_TRI]) begin
            wave_next = wave_next & tri_w;
            any_sel   = 1'b1;
        end
        if (ctrl[CTRL_SAW]) begin
            wave_next = wave_next & saw_w;
            any_sel   = 1'b1;
        end
        if (ctrl[CTRL_PULSE]) begin
            wave_next = wave_next & pulse_w;
            any_sel   = 1'b1;
        end
        if (ctrl[CTRL_NOISE]) begin
            wave_next = wave_next & noise_w;
            any_sel   = 1'b1;
        end
        if (!any_sel) begin
            wave_next = 12'h000;
        end
    end

    // Output sample register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waveOut <= 12'h000;
        end else begin
            waveOut <= wave_next;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// tb/tb_wave_gen.sv - randomized scoreboard bench for wave_gen against a behavioural model
module tb_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] accIn = '0;
    logic [7:0]  ctrl = '0;
    logic [11:0] pw = '0;
    logic        ringMsb = 1'b0;
    logic [11:0] waveOut;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] wave;
        logic [22:0] lfsr;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [22:0] m_lfsr = 23'h7FFFF8;
    logic        m_prev = 1'b0;

    wave_gen dut (
        .clk     (clk),
        .rst     (rst),
        .accIn   (accIn),
        .ctrl    (ctrl),
        .pw      (pw),
        .ringMsb (ringMsb),
        .waveOut (waveOut)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_wave(input logic [23:0] acc, input logic [7:0] c,
                                               input logic [11:0] p, input logic rm,
                                               input logic [22:0] l);
        int          taps [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
        logic [11:0] phase;
        logic [11:0] field;
        logic        msb;
        logic [11:0] tri_v;
        logic [11:0] pulse_v;
        logic [11:0] noise_v;
        logic [11:0] r;
        phase = acc[23:12];
        field = acc[22:11];
        msb   = acc[23];
`ifdef WAVE_GEN_RING_MOD_EN
        if (c[2]) msb = msb ^ rm;
`else
        msb = msb ^ (rm & 1'b0);
`endif
        tri_v   = msb ? (12'hFFF - field) : field;
        pulse_v = (phase >= p || c[3]) ? 12'hFFF : 12'h000;
        noise_v = 12'h000;
        for (int i = 0; i < 8; i++) noise_v = noise_v | (12'(l[taps[i]]) << (11 - i));
        if (c[7:4] == 4'b0000) return 12'h000;
        r = 12'hFFF;
        if (c[4]) r = r & tri_v;
        if (c[5]) r = r & phase;
        if (c[6]) r = r & pulse_v;
        if (c[7]) r = r & noise_v;
        return r;
    endfunction

    // One clock of stimulus: drive inputs, predict the response after the next edge.
    task automatic apply(input logic r, input logic [23:0] acc, input logic [7:0] c,
                         input logic [11:0] p, input logic rm, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; accIn = acc; ctrl = c; pw = p; ringMsb = rm;
        if (!r) begin
            e.wave = 12'h000;
            m_lfsr = 23'h7FFFF8;
            m_prev = 1'b0;
        end else begin
            e.wave = model_wave(acc, c, p, rm, m_lfsr);
            if (c[3]) m_lfsr = 23'h7FFFF8;
            else if (acc[19] && !m_prev)
                m_lfsr = ((m_lfsr << 1) & 23'h7FFFFF) | 23'(m_lfsr[22] ^ m_lfsr[17]);
            m_prev = acc[19];
        end
        e.lfsr = m_lfsr;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: the newest entry belongs to the edge still to come, so pop only older ones.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                n_checks++;
                if (waveOut !== e.wave) begin
                    n_fail++;
                    $display("FAIL %s wave: got %h expected %h", e.tag, waveOut, e.wave);
                end
                n_checks++;
                if (dut.lfsr_state !== e.lfsr) begin
                    n_fail++;
                    $display("FAIL %s lfsr: got %h expected %h", e.tag, dut.lfsr_state, e.lfsr);
                end
            end
        end
    end

    initial begin
        logic [7:0] c;
        apply(0, 24'h0, 8'h00, 12'h0, 0, "reset");
        apply(0, 24'h0, 8'h20, 12'h0, 0, "reset_hold");
        apply(1, 24'hABC123, 8'h20, 12'h0, 0, "saw_abc");
        apply(1, 24'h800000, 8'h10, 12'h0, 0, "tri_top");
        apply(1, 24'h000800, 8'h10, 12'h0, 0, "tri_low");
`ifdef WAVE_GEN_RING_MOD_EN
        apply(1, 24'h000800, 8'h14, 12'h0, 1, "tri_ring");
`endif
        apply(1, 24'h7FF000, 8'h40, 12'h800, 0, "pulse_below");
        apply(1, 24'h800000, 8'h40, 12'h800, 0, "pulse_at");
        apply(1, 24'h000000, 8'h48, 12'h800, 0, "pulse_test0");
        apply(1, 24'h123456, 8'h48, 12'hFFF, 0, "pulse_test1");
        apply(1, 24'h000000, 8'h40, 12'h000, 0, "pulse_pw0");
        apply(1, 24'hFFE000, 8'h40, 12'hFFF, 0, "pulse_pwmax_lo");
        apply(1, 24'hFFF000, 8'h40, 12'hFFF, 0, "pulse_pwmax_hi");
        apply(1, 24'hF00000, 8'h60, 12'h100, 0, "saw_and_pulse");
        apply(1, 24'hF00000, 8'h00, 12'h100, 0, "none_selected");
        // Noise: fresh reset, then bit 19 rises, falls, holds, rises again
        apply(0, 24'h0, 8'h80, 12'h0, 0, "noise_reset");
        apply(1, 24'h000000, 8'h80, 12'h0, 0, "noise_low");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_rise1");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_hold_hi");
        apply(1, 24'h000000, 8'h80, 12'h0, 0, "noise_fall");
        apply(1, 24'h000000, 8'h80, 12'h0, 0, "noise_hold_lo");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_rise2");
        apply(1, 24'h000000, 8'h80, 12'h0, 0, "noise_fall2");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_rise3");
        apply(0, 24'h080000, 8'h80, 12'h0, 0, "noise_midreset");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_first_after_rst");
        apply(1, 24'h080000, 8'h88, 12'h0, 0, "noise_test_hold");
        apply(1, 24'h000000, 8'h88, 12'h0, 0, "noise_test_low");
        apply(1, 24'h080000, 8'h80, 12'h0, 0, "noise_resume");
        for (int i = 0; i < 400; i++) begin
            c = 8'($urandom);
            if ($urandom_range(0, 7) != 0) c[3] = 1'b0;
            apply(($urandom_range(0, 39) != 0), 24'($urandom), c, 12'($urandom),
                  1'($urandom), "random");
        end
        apply(1, 24'h0, 8'h00, 12'h0, 0, "flush");
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
